// File: rtl/timebase_ctrl.sv
// Run/stop sequencer and double-buffered period/prescale for the PWM timebase.
// Config writes land at a period boundary while running, or on the next edge when idle.
module timebase_ctrl #(
  parameter int                    APB_DWIDTH = 8,
  parameter logic [APB_DWIDTH-1:0] PERIOD_RST = 8'hFF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  start,
  input  logic                  stop,
  input  logic [APB_DWIDTH-1:0] burst_len,
  input  logic [APB_DWIDTH-1:0] period_wr,
  input  logic [APB_DWIDTH-1:0] prescale_wr,
  input  logic                  upd_req,
  input  logic [APB_DWIDTH-1:0] period_cnt,
  input  logic                  sync_pulse,
  output logic [APB_DWIDTH-1:0] period_reg,
  output logic [APB_DWIDTH-1:0] prescale_reg,
  output logic                  tb_resetn,
  output logic                  running,
  output logic                  upd_pending,
  output logic                  upd_ack,
  output logic                  period_end,
  output logic                  burst_done
);

  typedef struct packed {
    logic [APB_DWIDTH-1:0] period;
    logic [APB_DWIDTH-1:0] prescale;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t                state_q, state_d;
  cfg_t                  active_q, active_d;
  cfg_t                  stage_q, stage_d, stage_eff;
  logic                  upd_pending_q, upd_pending_d;
  logic                  upd_ack_q, upd_ack_d;
  logic                  burst_done_q, burst_done_d;
  logic                  tb_resetn_q, tb_resetn_d;
  logic                  running_q, running_d;
  logic [APB_DWIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic [APB_DWIDTH-1:0] burst_len_q, burst_len_d;
  logic                  pend_eff;
  logic                  apply;
  logic                  burst_last;

  assign period_end = tb_resetn_q & sync_pulse & (period_cnt >= active_q.period);

  // A write arriving in the apply cycle bypasses staging so the newest value wins.
  always_comb begin
    stage_eff     = upd_req ? {period_wr, prescale_wr} : stage_q;
    pend_eff      = upd_req | upd_pending_q;
    apply         = pend_eff & ((state_q == IDLE) | period_end);
    stage_d       = stage_eff;
    active_d      = apply ? stage_eff : active_q;
    upd_pending_d = pend_eff & ~apply;
    upd_ack_d     = apply;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    burst_cnt_d = burst_cnt_q;
    burst_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = RUN;
          burst_len_d = burst_len;
          burst_cnt_d = '0;
        end
      end
      RUN: begin
        if (period_end) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          burst_last  = (burst_len_q != '0) && (burst_cnt_d == burst_len_q);
          if (burst_last || stop) state_d = IDLE;
        end else if (stop) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (period_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with state_q.
  always_comb begin
    tb_resetn_d  = (state_d != IDLE);
    running_d    = (state_d != IDLE);
    burst_done_d = burst_last;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      active_q      <= {PERIOD_RST, {APB_DWIDTH{1'b0}}};
      stage_q       <= '0;
      upd_pending_q <= 1'b0;
      upd_ack_q     <= 1'b0;
      burst_done_q  <= 1'b0;
      tb_resetn_q   <= 1'b0;
      running_q     <= 1'b0;
      burst_cnt_q   <= '0;
      burst_len_q   <= '0;
    end else begin
      active_q      <= active_d;
      stage_q       <= stage_d;
      upd_pending_q <= upd_pending_d;
      upd_ack_q     <= upd_ack_d;
      burst_done_q  <= burst_done_d;
      tb_resetn_q   <= tb_resetn_d;
      running_q     <= running_d;
      burst_cnt_q   <= burst_cnt_d;
      burst_len_q   <= burst_len_d;
    end
  end

  assign period_reg   = active_q.period;
  assign prescale_reg = active_q.prescale;
  assign tb_resetn    = tb_resetn_q;
  assign running      = running_q;
  assign upd_pending  = upd_pending_q;
  assign upd_ack      = upd_ack_q;
  assign burst_done   = burst_done_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench for timebase_ctrl with a small behavioural timebase driving
// period_cnt/sync_pulse: period lasts (period+1)*(prescale+1) clocks.
module tb_timebase_ctrl;
  logic       PCLK;
  logic       PRESET;
  logic       start, stop, upd_req;
  logic [7:0] burst_len, period_wr, prescale_wr;
  logic [7:0] period_cnt;
  logic       sync_pulse;
  logic [7:0] period_reg, prescale_reg;
  logic       tb_resetn, running, upd_pending, upd_ack, period_end, burst_done;
  logic [7:0] presc_cnt;

  int checks   = 0;
  int failures = 0;

  timebase_ctrl #(.APB_DWIDTH(8), .PERIOD_RST(8'hFF)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .stop(stop),
    .burst_len(burst_len), .period_wr(period_wr), .prescale_wr(prescale_wr),
    .upd_req(upd_req), .period_cnt(period_cnt), .sync_pulse(sync_pulse),
    .period_reg(period_reg), .prescale_reg(prescale_reg), .tb_resetn(tb_resetn),
    .running(running), .upd_pending(upd_pending), .upd_ack(upd_ack),
    .period_end(period_end), .burst_done(burst_done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    period_cnt = '0;
    presc_cnt  = '0;
  end

  // Timebase stand-in: held while tb_resetn=0, wraps when count reaches period.
  assign sync_pulse = tb_resetn & (presc_cnt == prescale_reg);
  always @(posedge PCLK) begin
    if (!tb_resetn) begin
      period_cnt <= '0;
      presc_cnt  <= '0;
    end else if (sync_pulse) begin
      presc_cnt  <= '0;
      period_cnt <= (period_cnt >= period_reg) ? 8'd0 : period_cnt + 8'd1;
    end else begin
      presc_cnt  <= presc_cnt + 8'd1;
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_end(input int max, output int n);
    n = 0;
    while (!period_end && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    step();
    step();
    checks++; if (period_reg !== 8'hFF) begin failures++; $display("FAIL rst_period got=%0h exp=ff", period_reg); end
    checks++; if (prescale_reg !== 8'h00) begin failures++; $display("FAIL rst_prescale got=%0h exp=0", prescale_reg); end
    checks++; if ({tb_resetn, running, upd_pending, upd_ack, burst_done} !== 5'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=00000", {tb_resetn, running, upd_pending, upd_ack, burst_done}); end
    PRESET = 1'b0;
    step();
  endtask

  task automatic test_idle_update();
    period_wr = 8'd4; prescale_wr = 8'd1; upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    checks++; if (period_reg !== 8'd4) begin failures++; $display("FAIL idle_upd_period got=%0d exp=4", period_reg); end
    checks++; if (prescale_reg !== 8'd1) begin failures++; $display("FAIL idle_upd_prescale got=%0d exp=1", prescale_reg); end
    checks++; if ({upd_ack, upd_pending, tb_resetn} !== 3'b100) begin
      failures++; $display("FAIL idle_upd_flags got=%b exp=100", {upd_ack, upd_pending, tb_resetn}); end
    step();
    checks++; if (upd_ack !== 1'b0) begin failures++; $display("FAIL idle_upd_ack_pulse got=%b exp=0", upd_ack); end
  endtask

  task automatic test_burst();
    int ends, bd, bd_cyc;
    int end_cyc [3];
    ends = 0; bd = 0; bd_cyc = -1;
    end_cyc[0] = -1; end_cyc[1] = -1; end_cyc[2] = -1;
    burst_len = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({tb_resetn, running} !== 2'b11) begin failures++; $display("FAIL burst_start got=%b exp=11", {tb_resetn, running}); end
    for (int i = 0; i < 50; i++) begin
      if (period_end) begin
        if (ends < 3) end_cyc[ends] = i;
        ends++;
      end
      if (burst_done) begin
        bd++;
        bd_cyc = i;
        checks++; if ({tb_resetn, running} !== 2'b00) begin
          failures++; $display("FAIL burst_done_hold got=%b exp=00", {tb_resetn, running}); end
      end
      step();
    end
    checks++; if (ends !== 3) begin failures++; $display("FAIL burst_end_count got=%0d exp=3", ends); end
    checks++; if (end_cyc[0] !== 9 || end_cyc[1] !== 19 || end_cyc[2] !== 29) begin
      failures++; $display("FAIL burst_end_cycles got=%0d,%0d,%0d exp=9,19,29", end_cyc[0], end_cyc[1], end_cyc[2]); end
    checks++; if (bd !== 1 || bd_cyc !== 30) begin
      failures++; $display("FAIL burst_done_pulse got=%0d@%0d exp=1@30", bd, bd_cyc); end
  endtask

  // Covers last-write-wins staging, boundary apply, and stop coincident with period_end.
  task automatic test_midrun_update();
    int cyc, n;
    burst_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    period_wr = 8'd7; prescale_wr = 8'd1; upd_req = 1'b1;
    step();
    checks++; if (upd_pending !== 1'b1) begin failures++; $display("FAIL mid_pending_set got=%b exp=1", upd_pending); end
    period_wr = 8'd2;
    step();
    upd_req = 1'b0;
    cyc = 5;
    while (!period_end && cyc < 30) begin
      checks++; if (period_reg !== 8'd4 || upd_pending !== 1'b1) begin
        failures++; $display("FAIL mid_hold got=%0d/%b exp=4/1", period_reg, upd_pending); end
      step();
      cyc++;
    end
    checks++; if (cyc !== 9) begin failures++; $display("FAIL mid_first_end got=%0d exp=9", cyc); end
    step();
    checks++; if (period_reg !== 8'd2 || prescale_reg !== 8'd1) begin
      failures++; $display("FAIL mid_apply got=%0d/%0d exp=2/1", period_reg, prescale_reg); end
    checks++; if ({upd_ack, upd_pending} !== 2'b10) begin
      failures++; $display("FAIL mid_apply_flags got=%b exp=10", {upd_ack, upd_pending}); end
    wait_end(20, n);
    checks++; if (n !== 5 || period_cnt !== 8'd2) begin
      failures++; $display("FAIL mid_new_period got=%0d cyc cnt=%0d exp=5 cyc cnt=2", n, period_cnt); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if ({tb_resetn, running, burst_done} !== 3'b000) begin
      failures++; $display("FAIL mid_stop_at_end got=%b exp=000", {tb_resetn, running, burst_done}); end
  endtask

  task automatic test_graceful_stop();
    int n, bd;
    bd = 0;
    burst_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (period_cnt !== 8'd1 && n < 20) begin step(); n++; end
    checks++; if (n !== 2) begin failures++; $display("FAIL stop_reach_cnt1 got=%0d exp=2", n); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if ({tb_resetn, running} !== 2'b11) begin failures++; $display("FAIL stopping_state got=%b exp=11", {tb_resetn, running}); end
    n = 0;
    while (!period_end && n < 20) begin
      if (burst_done) bd++;
      step();
      n++;
    end
    checks++; if (n !== 2 || period_cnt !== 8'd2) begin
      failures++; $display("FAIL stop_boundary got=%0d cyc cnt=%0d exp=2 cyc cnt=2", n, period_cnt); end
    step();
    checks++; if ({tb_resetn, running, burst_done} !== 3'b000 || bd !== 0) begin
      failures++; $display("FAIL stop_idle got=%b bd=%0d exp=000 bd=0", {tb_resetn, running, burst_done}, bd); end
  endtask

  task automatic test_collisions();
    int n;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if ({tb_resetn, running} !== 2'b00) begin failures++; $display("FAIL start_stop_idle got=%b exp=00", {tb_resetn, running}); end
    step();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL start_stop_idle2 got=%b exp=0", running); end

    burst_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    wait_end(20, n);
    checks++; if (period_end !== 1'b1) begin failures++; $display("FAIL coll_wait_end got=%b exp=1", period_end); end
    period_wr = 8'd3; prescale_wr = 8'd0; upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    checks++; if (period_reg !== 8'd3 || prescale_reg !== 8'd0) begin
      failures++; $display("FAIL upd_at_end got=%0d/%0d exp=3/0", period_reg, prescale_reg); end
    checks++; if ({upd_ack, upd_pending} !== 2'b10) begin
      failures++; $display("FAIL upd_at_end_flags got=%b exp=10", {upd_ack, upd_pending}); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_end(20, n);
    step();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL coll_stop_idle got=%b exp=0", running); end

    burst_len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_end(20, n);
    step();
    wait_end(20, n);
    checks++; if (period_end !== 1'b1 || n !== 3) begin
      failures++; $display("FAIL final_end got=%b n=%0d exp=1 n=3", period_end, n); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if ({burst_done, tb_resetn, running} !== 3'b100) begin
      failures++; $display("FAIL stop_on_final got=%b exp=100", {burst_done, tb_resetn, running}); end
  endtask

  task automatic test_reset_midburst();
    burst_len = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    period_wr = 8'd9; prescale_wr = 8'd2; upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    checks++; if (upd_pending !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%b exp=1", upd_pending); end
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    checks++; if (period_reg !== 8'hFF || prescale_reg !== 8'h00) begin
      failures++; $display("FAIL rmid_regs got=%0h/%0h exp=ff/0", period_reg, prescale_reg); end
    checks++; if ({tb_resetn, running, upd_pending, upd_ack, burst_done} !== 5'b0) begin
      failures++; $display("FAIL rmid_flags got=%b exp=00000", {tb_resetn, running, upd_pending, upd_ack, burst_done}); end
    step();
    checks++; if ({burst_done, running} !== 2'b00) begin failures++; $display("FAIL rmid_after got=%b exp=00", {burst_done, running}); end
  endtask

  initial begin
    PRESET = 1'b1; start = 1'b0; stop = 1'b0; upd_req = 1'b0;
    burst_len = '0; period_wr = '0; prescale_wr = '0;
    test_reset();
    test_idle_update();
    test_burst();
    test_midrun_update();
    test_graceful_stop();
    test_collisions();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timebase_ctrl.md
Name: timebase_ctrl

Overview:
- Sequencing and configuration controller for the PWM timebase counter.
- Holds the timebase in reset while idle and runs it for continuous or N-period bursts.
- Stops gracefully at a period boundary.
- Double-buffers period/prescale so register writes reach the timebase only at a period boundary, or immediately when idle.
- Sits between the APB register file and the timebase instance.

Parameters:
APB_DWIDTH, 8, width of period, prescale, burst and counter buses
PERIOD_RST, 8'hFF, reset value of period_reg (must fit APB_DWIDTH)

Ports:
PCLK  in  1  clock
PRESET  in  1  reset; one clock; reset is synchronous and active-high
start  in  1  single-cycle run request
stop  in  1  single-cycle graceful stop request
burst_len  in  APB_DWIDTH  periods per run; 0 = continuous; sampled on accepted start
period_wr  in  APB_DWIDTH  staged period value from register file
prescale_wr  in  APB_DWIDTH  staged prescale value from register file
upd_req  in  1  single-cycle: capture period_wr/prescale_wr into staging
period_cnt  in  APB_DWIDTH  timebase period counter
sync_pulse  in  1  timebase prescale-terminal indication
period_reg  out  APB_DWIDTH  active period to timebase
prescale_reg  out  APB_DWIDTH  active prescale to timebase
tb_resetn  out  1  registered active-low hold for timebase (0 = held)
running  out  1  state != IDLE
upd_pending  out  1  staged values not yet applied
upd_ack  out  1  one-cycle pulse when staged values are applied
period_end  out  1  combinational boundary indication
burst_done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset, synchronous on PCLK while PRESET=1:
  - state=IDLE, period_reg=PERIOD_RST, prescale_reg=0, staging=0.
  - tb_resetn=0, upd_pending=0, upd_ack=0, burst_done=0, burst_cnt=0, latched burst_len=0.
  - Reset asserted mid-run aborts immediately with no burst_done.
- Boundary: period_end = tb_resetn & sync_pulse & (period_cnt >= period_reg). Compare is unsigned, full width.
- Staging:
  - upd_req loads staging from period_wr/prescale_wr and sets upd_pending.
  - A repeat upd_req before apply overwrites staging (last write wins).
- Apply:
  - Registers load from staging, upd_pending clears and upd_ack pulses on the cycle after the apply condition.
  - Apply condition in IDLE: upd_pending=1, so the update lands 1 cycle after upd_req.
  - Apply condition in RUN/STOPPING: period_end=1.
  - upd_req coincident with period_end uses the new period_wr/prescale_wr at that boundary.
  - upd_req coincident with an apply in IDLE applies the new value and leaves upd_pending=0.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: tb_resetn=0. On start=1 and stop=0: latch burst_len, burst_cnt=0, go RUN; tb_resetn=1 next cycle. start with stop in the same cycle stays IDLE.
  - RUN: start ignored. stop goes to STOPPING. On period_end, burst_cnt increments (wraps modulo 2^APB_DWIDTH when continuous).
  - RUN, burst end: if latched burst_len != 0 and burst_cnt+1 == burst_len at period_end, go IDLE, pulse burst_done and drop tb_resetn on the next cycle.
  - RUN, stop and period_end in the same cycle: go IDLE directly, with no burst_done unless the burst also completed.
  - STOPPING: start and stop ignored. On period_end, go IDLE with no burst_done; a pending update still applies at that boundary.
- Latency: start to tb_resetn=1 is 1 cycle. Final boundary to tb_resetn=0 is 1 cycle. running tracks state with the same registered timing.
- Any period_reg or prescale_reg change while tb_resetn=1 is legal only at a period_end.

Test Plan:
- Reset, then idle update: PRESET high 2 cycles → period_reg=0xFF, prescale_reg=0, tb_resetn=0, running=0. Then upd_req with period_wr=4, prescale_wr=1 → next cycle period_reg=4, prescale_reg=1, upd_ack=1 for 1 cycle, upd_pending=0.
- Burst of 3: period=4, prescale=1, burst_len=3, start → tb_resetn=1 after 1 cycle. Exactly 3 period_end pulses (every 10 cycles), then burst_done for 1 cycle and tb_resetn=0, running=0.
- Mid-run update: continuous run with period=4; upd_req period_wr=2 mid-period → period_reg stays 4 until period_end, then 2. upd_pending high throughout. Next period length is 3 timebase steps.
- Graceful stop: stop issued at period_cnt=1 → state STOPPING, timebase keeps counting to the boundary. tb_resetn=0 one cycle after period_end; no burst_done.
- Collisions: start+stop in IDLE → stays IDLE. upd_req on the period_end cycle → new values applied at that boundary. stop on the final burst boundary → IDLE with burst_done=1.
- Reset mid-burst: PRESET during RUN → next cycle tb_resetn=0, period_reg=0xFF, upd_pending=0, no burst_done pulse.
